// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the Subarashii fetch stage.
//   CPU_ADDR_W   : PC / instruction memory word-address width
//   CPU_DATA_W   : instruction width
//   CPU_RESET_PC : PC value after reset
//   fetch_state_e: fetch FSM state encoding
package fetch_unit_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_DATA_W = 16;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_BLOCK = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction buffer between fetch and decode: an output register
// presented to decode plus a skid register that catches one extra word when
// decode stalls. Strict FIFO order; flush empties both entries.
//   clk, rst            : clock, asynchronous active-low reset
//   flush               : drop both entries (redirect)
//   in_valid/data/pc    : word arriving from instruction memory
//   out_valid/ready     : handshake with decode
//   out_data/pc         : instruction and its address
//   skid_valid          : skid register occupied
module fetch_buf #(
    parameter int ADDR_W = fetch_unit_pkg::CPU_ADDR_W,
    parameter int DATA_W = fetch_unit_pkg::CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic              skid_valid
);

    logic              out_valid_d,  out_valid_q;
    logic [DATA_W-1:0] out_data_d,   out_data_q;
    logic [ADDR_W-1:0] out_pc_d,     out_pc_q;
    logic              skid_valid_d, skid_valid_q;
    logic [DATA_W-1:0] skid_data_d,  skid_data_q;
    logic [ADDR_W-1:0] skid_pc_d,    skid_pc_q;
    logic              consume;

    assign consume = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves a
        // value unassigned (which would infer a latch); blocking '=' is
        // correct here because this block is combinational.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Drain: the older skid word moves up once decode takes the head.
            if (consume) begin
                out_data_d   = skid_data_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = in_valid;
                if (in_valid) begin
                    skid_data_d = in_data;
                    skid_pc_d   = in_pc;
                end
            end
        end else if (in_valid) begin
            if (!out_valid_q || consume) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_pc_d    = in_pc;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_pc_d    = in_pc;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the data/pc registers are reset as well, because decode must see
    // inst_data=0 and inst_pc=0 straight out of reset; state uses '<=' only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_pc     = out_pc_q;
    assign skid_valid = skid_valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads over a req/ack
// handshake and hands instructions to decode through fetch_buf.
//   clk, rst              : clock, asynchronous active-low reset
//   imem_req/addr         : read request, held stable until imem_ack
//   imem_ack/rdata        : one-cycle read response
//   redirect_valid/pc     : branch/jump redirect (highest priority)
//   inst_valid/ready      : handshake with decode
//   inst_data/pc          : instruction and its address
module fetch_unit #(
    parameter int                ADDR_W   = fetch_unit_pkg::CPU_ADDR_W,
    parameter int                DATA_W   = fetch_unit_pkg::CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_unit_pkg::CPU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    import fetch_unit_pkg::*;

    fetch_state_e      state_d, state_q;
    logic [ADDR_W-1:0] pc_d,    pc_q;
    logic [ADDR_W-1:0] addr_d,  addr_q;
    logic              req_d,   req_q;
    logic              drop_d,  drop_q;

    logic [ADDR_W-1:0] pc_inc;
    logic              ack_fire;
    logic              buf_in_valid;
    logic              to_skid;
    logic              skid_valid;

    // Acks are only meaningful against our own outstanding request.
    assign ack_fire     = req_q & imem_ack;
    assign buf_in_valid = ack_fire & ~drop_q & ~redirect_valid;
    // The head is occupied and not leaving, so this word lands in the skid.
    assign to_skid      = buf_in_valid & inst_valid & ~inst_ready;
    assign pc_inc       = pc_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        drop_d  = drop_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (ack_fire) begin
                        drop_d = 1'b0;
                        addr_d = redirect_pc;
                    end else begin
                        // The bus request cannot be withdrawn; swallow its ack.
                        drop_d = 1'b1;
                    end
                end else if (ack_fire && drop_q) begin
                    drop_d = 1'b0;
                    addr_d = pc_q;
                end else if (ack_fire) begin
                    pc_d = pc_inc;
                    if (to_skid) begin
                        state_d = ST_BLOCK;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = pc_inc;
                    end
                end
            end
            ST_BLOCK: begin
                if (redirect_valid) begin
                    state_d = ST_FETCH;
                    pc_d    = redirect_pc;
                    req_d   = 1'b1;
                    addr_d  = redirect_pc;
                end else if (!skid_valid) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .in_valid   (buf_in_valid),
        .in_data    (imem_rdata),
        .in_pc      (addr_q),
        .out_valid  (inst_valid),
        .out_ready  (inst_ready),
        .out_data   (inst_data),
        .out_pc     (inst_pc),
        .skid_valid (skid_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Memory word at address N is 16'hA000+N.
// The reference model is the instruction stream itself: decode must receive
// consecutive addresses starting at RESET_PC, restarting at each redirect
// target, with data equal to the memory contents at that address.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_deliv  = 0;
    logic [15:0] exp_pc;
    logic [15:0] got_pc[$];

    typedef struct {
        logic        rst;
        logic        ack;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // One clock cycle: drive at the falling edge, score the decode handshake,
    // then check hold / flush rules after the following rising edge.
    task automatic cyc(input logic ack, input logic ready, input logic redir, input logic [15:0] rpc);
        logic        hold_out;
        logic        hold_req;
        logic [15:0] h_pc;
        logic [15:0] h_data;
        logic [15:0] h_addr;
        logic [15:0] e_data;
        imem_ack       = ack;
        imem_rdata     = (ack && imem_req) ? 16'hA000 + imem_addr : 16'hDEAD;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (inst_valid && ready) begin
            e_data = 16'hA000 + exp_pc;
            check("stream_pc", inst_pc, exp_pc);
            check("stream_data", inst_data, e_data);
            got_pc.push_back(inst_pc);
            exp_pc = exp_pc + 16'd1;
            n_deliv++;
        end
        if (redir) exp_pc = rpc;
        hold_out = inst_valid && !ready && !redir;
        h_pc     = inst_pc;
        h_data   = inst_data;
        hold_req = imem_req && !ack;
        h_addr   = imem_addr;
        @(posedge clk);
        @(negedge clk);
        if (hold_out) begin
            check("hold_valid", inst_valid, 1);
            check("hold_pc", inst_pc, h_pc);
            check("hold_data", inst_data, h_data);
        end
        if (hold_req) begin
            check("hold_req", imem_req, 1);
            check("hold_addr", imem_addr, h_addr);
        end
        if (redir) check("redirect_flush", inst_valid, 0);
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        rst            = 1'b0;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_addr", imem_addr, 16'h0000);
        rst    = 1'b1;
        exp_pc = 16'h0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_acc;
        int          d0;
        logic [15:0] e_data;

        rst            = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 16'h0000;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        inst_ready     = 1'b0;

        // Startup: memory acks each request on its second cycle, decode always ready.
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0001};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0002};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            rst        = vecs[i].rst;
            imem_ack   = vecs[i].ack;
            inst_ready = vecs[i].ready;
            imem_rdata = 16'hA000 + imem_addr;
            #1;
            check($sformatf("tbl%0d_req", i), imem_req, vecs[i].e_req);
            check($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("tbl%0d_valid", i), inst_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                e_data = 16'hA000 + vecs[i].e_pc;
                check($sformatf("tbl%0d_pc", i), inst_pc, vecs[i].e_pc);
                check($sformatf("tbl%0d_data", i), inst_data, e_data);
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        exp_pc   = 16'h0003;

        // Backpressure: decode stalls 6 cycles while memory acks everything
        // (including spurious acks once the request drops).
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req) n_acc++;
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
        end
        check("bp_accepted", n_acc, 2);
        check("bp_block_req", imem_req, 0);
        check("bp_valid", inst_valid, 1);
        check("bp_head_pc", inst_pc, exp_pc);
        d0 = n_deliv;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        check("bp_drained", n_deliv - d0, 2);
        check("bp_refetch_req", imem_req, 1);
        check("bp_refetch_addr", imem_addr, exp_pc);
        check("bp_empty", inst_valid, 0);

        // Redirect while a request to 0x0004 is outstanding; ack 3 cycles later.
        do_reset();
        for (int k = 0; k < 20 && imem_addr != 16'h0004; k++) cyc(imem_req, 1'b1, 1'b0, 16'h0000);
        check("reach_addr4", imem_addr, 16'h0004);
        cyc(1'b0, 1'b1, 1'b1, 16'h0100);
        check("drop_req_held", imem_req, 1);
        check("drop_addr_held", imem_addr, 16'h0004);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        check("drop_discarded", inst_valid, 0);
        check("drop_next_addr", imem_addr, 16'h0100);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        check("redir_valid", inst_valid, 1);
        check("redir_pc", inst_pc, 16'h0100);
        check("redir_data", inst_data, 16'hA100);

        // Redirect in the same cycle as an ack and a decode handshake.
        d0 = n_deliv;
        cyc(1'b1, 1'b1, 1'b1, 16'h0200);
        check("coinc_handshake", n_deliv - d0, 1);
        check("coinc_next_addr", imem_addr, 16'h0200);
        check("coinc_req", imem_req, 1);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        check("coinc_no_drop_valid", inst_valid, 1);
        check("coinc_pc", inst_pc, 16'h0200);

        // PC wrap through 0xFFFF.
        cyc(1'b0, 1'b1, 1'b1, 16'hFFFF);
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        check("wrap_addr", imem_addr, 16'hFFFF);
        got_pc.delete();
        for (int k = 0; k < 10 && got_pc.size() < 3; k++) cyc(imem_req, 1'b1, 1'b0, 16'h0000);
        check("wrap_count", got_pc.size() >= 3, 1);
        if (got_pc.size() >= 3) begin
            check("wrap_pc0", got_pc[0], 16'hFFFF);
            check("wrap_pc1", got_pc[1], 16'h0000);
            check("wrap_pc2", got_pc[2], 16'h0001);
        end

        // Asynchronous reset between clock edges while streaming.
        cyc(imem_req, 1'b1, 1'b0, 16'h0000);
        check("async_pre_valid", inst_valid, 1);
        check("async_pre_req", imem_req, 1);
        #2 rst = 1'b0;
        #1;
        check("async_req", imem_req, 0);
        check("async_valid", inst_valid, 0);
        check("async_data", inst_data, 16'h0000);
        @(negedge clk);
        rst    = 1'b1;
        exp_pc = 16'h0000;
        got_pc.delete();
        for (int k = 0; k < 12 && got_pc.size() < 2; k++) cyc(imem_req, 1'b1, 1'b0, 16'h0000);
        check("restart_count", got_pc.size() >= 2, 1);
        if (got_pc.size() >= 2) begin
            check("restart_pc0", got_pc[0], 16'h0000);
            check("restart_pc1", got_pc[1], 16'h0001);
        end

        // Randomized traffic against the stream model.
        d0 = n_deliv;
        for (int i = 0; i < 3000; i++) begin
            logic        a;
            logic        r;
            logic        d;
            logic [15:0] t;
            a = imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 39) == 0);
            t = 16'($urandom);
            if ($urandom_range(0, 3) == 0) t = 16'hFFFE;
            cyc(a, r, d, t);
        end
        check("random_progress", (n_deliv - d0) > 300, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
